// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned CTI_W       = 3;
  localparam int unsigned BTE_W       = 2;
  localparam int unsigned GNT_W       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  // One-hot grant vector presented for a given arbiter state.
  function automatic logic [GNT_W-1:0] gnt_vec(arb_state_t s);
    logic [GNT_W-1:0] v;
    v = '0;
    case (s)
      GNT0:    v = 2'b01;
      GNT1:    v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wshb_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one Wishbone slave (SDRAM port)
// between the video reader (m0) and the stream/host writer (m1).
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADR_W      = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADR_W-1:0]        m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [CTI_W-1:0]        m0_cti,
  input  logic [BTE_W-1:0]        m0_bte,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADR_W-1:0]        m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [CTI_W-1:0]        m1_cti,
  input  logic [BTE_W-1:0]        m1_bte,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADR_W-1:0]        s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [CTI_W-1:0]        s_cti,
  output logic [BTE_W-1:0]        s_bte,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,

  output logic [GNT_W-1:0]        gnt,
  output logic [CNT_W-1:0]        gnt_cnt0,
  output logic [CNT_W-1:0]        gnt_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t state;
  arb_state_t state_next;
  logic       last_gnt;
  logic       enter0;
  logic       enter1;

  // State, round-robin history, grant vector and saturating grant counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= '0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_vec(state_next);
      if (enter0) last_gnt <= 1'b0;
      if (enter1) last_gnt <= 1'b1;
      if (enter0 && (gnt_cnt0 != CNT_MAX)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (enter1 && (gnt_cnt1 != CNT_MAX)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end

  // Next state: an owner keeps the bus until it drops cyc, then hands over directly.
  always_comb begin
    state_next = state;
    enter0     = 1'b0;
    enter1     = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_next = last_gnt ? GNT0 : GNT1;
        else if (m0_cyc)      state_next = GNT0;
        else if (m1_cyc)      state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc) state_next = m1_cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc) state_next = m0_cyc ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
    enter0 = (state_next == GNT0) && (state != GNT0);
    enter1 = (state_next == GNT1) && (state != GNT1);
  end

  // Zero-latency request/response routing for the current owner; idle drives all zero.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rty   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rty   = 1'b0;
    unique case (state)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        m0_err   = s_err;
        m0_rty   = s_rty;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        m1_err   = s_err;
        m1_rty   = s_rty;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the handshake strobes are steered.
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: directed scenarios plus a randomized
// phase, checked against a grant-ownership reference model.
module tb_wshb_arbiter;

  localparam int DB = 4;
  localparam int AW = 32;
  localparam int DW = 8 * DB;

  logic clk = 1'b0;
  logic rst;

  logic          cyc [2];
  logic          stb [2];
  logic          we  [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] dms [2];
  logic [DB-1:0] sel [2];
  logic [2:0]    cti [2];
  logic [1:0]    bte [2];

  logic [DW-1:0] s_dat_sm;
  logic          s_ack, s_err, s_rty;

  logic [DW-1:0] m0_dat_sm, m1_dat_sm;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_ms;
  logic [DB-1:0] s_sel;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [1:0]    gnt;
  logic [15:0]   gnt_cnt0, gnt_cnt1;

  logic [DW-1:0] x_dat_sm0, x_dat_sm1;
  logic          x_ack0, x_err0, x_rty0, x_ack1, x_err1, x_rty1;
  logic          x_cyc, x_stb, x_we;
  logic [AW-1:0] x_adr;
  logic [DW-1:0] x_dat_ms;
  logic [DB-1:0] x_sel;
  logic [2:0]    x_cti;
  logic [1:0]    x_bte;
  logic [1:0]    x_gnt;
  logic [2:0]    x_cnt0, x_cnt1;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, who won last, how many grants each got.
  int          owner;
  int          last_m;
  int unsigned mcnt [2];
  bit          ack_always;

  always #5 clk = ~clk;

  wshb_arbiter dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_adr(adr[0]),
    .m0_dat_ms(dms[0]), .m0_sel(sel[0]), .m0_cti(cti[0]), .m0_bte(bte[0]),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
    .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_adr(adr[1]),
    .m1_dat_ms(dms[1]), .m1_sel(sel[1]), .m1_cti(cti[1]), .m1_bte(bte[1]),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .gnt(gnt), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  wshb_arbiter #(.DATA_BYTES(DB), .ADR_W(AW), .CNT_W(3)) dut_sat (
    .sys_clk(clk), .sys_rst(rst),
    .m0_cyc(cyc[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_adr(adr[0]),
    .m0_dat_ms(dms[0]), .m0_sel(sel[0]), .m0_cti(cti[0]), .m0_bte(bte[0]),
    .m0_dat_sm(x_dat_sm0), .m0_ack(x_ack0), .m0_err(x_err0), .m0_rty(x_rty0),
    .m1_cyc(cyc[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_adr(adr[1]),
    .m1_dat_ms(dms[1]), .m1_sel(sel[1]), .m1_cti(cti[1]), .m1_bte(bte[1]),
    .m1_dat_sm(x_dat_sm1), .m1_ack(x_ack1), .m1_err(x_err1), .m1_rty(x_rty1),
    .s_cyc(x_cyc), .s_stb(x_stb), .s_we(x_we), .s_adr(x_adr), .s_dat_ms(x_dat_ms),
    .s_sel(x_sel), .s_cti(x_cti), .s_bte(x_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .gnt(x_gnt), .gnt_cnt0(x_cnt0), .gnt_cnt1(x_cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the arbitration rules to the inputs seen at this clock edge.
  task automatic model_edge();
    int nxt;
    if (rst) begin
      owner   = -1;
      last_m  = 1;
      mcnt[0] = 0;
      mcnt[1] = 0;
    end else begin
      nxt = owner;
      if (owner < 0) begin
        if (cyc[0] && cyc[1]) nxt = 1 - last_m;
        else if (cyc[0])      nxt = 0;
        else if (cyc[1])      nxt = 1;
      end else if (!cyc[owner]) begin
        nxt = cyc[1-owner] ? 1 - owner : -1;
      end
      if (nxt >= 0 && nxt != owner) begin
        last_m = nxt;
        mcnt[nxt]++;
      end
      owner = nxt;
    end
  endtask

  task automatic check_all();
    logic [1:0]  eg;
    logic [2:0]  rsp;
    int unsigned e0, e1, s0, s1;
    eg  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
    rsp = {s_ack, s_err, s_rty};
    check("gnt", 64'(gnt), 64'(eg));
    check("gnt_sat", 64'(x_gnt), 64'(eg));
    if (owner >= 0) begin
      check("s_cyc", 64'(s_cyc), 64'(cyc[owner]));
      check("s_stb", 64'(s_stb), 64'(stb[owner]));
      check("s_we",  64'(s_we),  64'(we[owner]));
      check("s_adr", 64'(s_adr), 64'(adr[owner]));
      check("s_dat_ms", 64'(s_dat_ms), 64'(dms[owner]));
      check("s_sel_cti_bte", 64'({s_sel, s_cti, s_bte}),
            64'({sel[owner], cti[owner], bte[owner]}));
    end else begin
      check("idle_ctl", 64'({s_cyc, s_stb, s_we, s_sel, s_cti, s_bte}), 64'd0);
      check("idle_adr", 64'(s_adr), 64'd0);
      check("idle_dat", 64'(s_dat_ms), 64'd0);
    end
    check("m0_rsp", 64'({m0_ack, m0_err, m0_rty}), 64'((owner == 0) ? rsp : 3'b000));
    check("m1_rsp", 64'({m1_ack, m1_err, m1_rty}), 64'((owner == 1) ? rsp : 3'b000));
    check("m0_dat_sm", 64'(m0_dat_sm), 64'(s_dat_sm));
    check("m1_dat_sm", 64'(m1_dat_sm), 64'(s_dat_sm));
    e0 = (mcnt[0] > 65535) ? 65535 : mcnt[0];
    e1 = (mcnt[1] > 65535) ? 65535 : mcnt[1];
    s0 = (mcnt[0] > 7) ? 7 : mcnt[0];
    s1 = (mcnt[1] > 7) ? 7 : mcnt[1];
    check("gnt_cnt0", 64'(gnt_cnt0), 64'(e0));
    check("gnt_cnt1", 64'(gnt_cnt1), 64'(e1));
    check("sat_cnt0", 64'(x_cnt0), 64'(s0));
    check("sat_cnt1", 64'(x_cnt1), 64'(s1));
  endtask

  task automatic payload();
    for (int i = 0; i < 2; i++) begin
      we[i]  = 1'($urandom_range(0, 1));
      adr[i] = AW'($urandom);
      dms[i] = DW'($urandom);
      sel[i] = DB'($urandom);
      cti[i] = 3'($urandom);
      bte[i] = 2'($urandom);
    end
    s_dat_sm = DW'($urandom);
    s_ack    = ack_always ? 1'b1 : 1'($urandom_range(0, 1));
    s_err    = 1'($urandom_range(0, 3) == 0);
    s_rty    = 1'($urandom_range(0, 3) == 0);
  endtask

  // One clock: model and DUT advance together, then all outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    payload();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    cyc[0] = 1'b0; cyc[1] = 1'b0;
    stb[0] = 1'b0; stb[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    owner      = -1;
    last_m     = 1;
    mcnt[0]    = 0;
    mcnt[1]    = 0;
    ack_always = 1'b1;
    payload();
    do_reset();
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_cnts", 64'({gnt_cnt0, gnt_cnt1}), 64'd0);

    // Single master with a slave that acks every cycle.
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    check("s31_latency", 64'(gnt), 64'd1);
    repeat (5) begin
      tick();
      check("s31_m0_ack", 64'(m0_ack), 64'd1);
      check("s31_m1_ack", 64'(m1_ack), 64'd0);
    end

    // Simultaneous requests after reset, then a direct handover.
    do_reset();
    cyc[0] = 1'b1; cyc[1] = 1'b1; stb[0] = 1'b1; stb[1] = 1'b1;
    tick();
    check("s32_first", 64'(gnt), 64'd1);
    repeat (8) tick();
    cyc[0] = 1'b0;
    tick();
    check("s32_handover", 64'(gnt), 64'd2);
    check("s32_cnt", 64'({gnt_cnt0, gnt_cnt1}), 64'({16'd1, 16'd1}));

    // Continuous contention: grants alternate, ten grants in total.
    do_reset();
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    tick();
    for (int g = 0; g < 10; g++) begin
      check("s33_order", 64'(gnt), 64'((g % 2 == 0) ? 2'b01 : 2'b10));
      if (g < 9) begin
        repeat (3) tick();
        cyc[g % 2] = 1'b0;
        tick();
        cyc[g % 2] = 1'b1;
      end
    end
    check("s33_cnt0", 64'(gnt_cnt0), 64'd5);
    check("s33_cnt1", 64'(gnt_cnt1), 64'd5);

    // Owner holding cyc with stb toggling is never preempted.
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stb[1] = ~stb[1];
      tick();
      check("s34_hold", 64'(gnt), 64'd2);
    end
    cyc[1] = 1'b0;
    tick();
    check("s34_switch", 64'(gnt), 64'd1);

    // Reset pulse in the middle of an m1 burst.
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (4) tick();
    rst = 1'b1; cyc[0] = 1'b1;
    tick();
    check("s35_gnt", 64'(gnt), 64'd0);
    check("s35_scyc", 64'(s_cyc), 64'd0);
    check("s35_cnts", 64'({gnt_cnt0, gnt_cnt1}), 64'd0);
    rst = 1'b0;
    tick();
    check("s35_m0_wins", 64'(gnt), 64'd1);

    // Nine grants to m0: the narrow counter saturates.
    do_reset();
    repeat (9) begin
      cyc[0] = 1'b1;
      tick();
      cyc[0] = 1'b0;
      tick();
    end
    check("s36_sat", 64'(x_cnt0), 64'd7);
    check("s36_wide", 64'(gnt_cnt0), 64'd9);

    // Randomized traffic with occasional resets and stray slave responses.
    ack_always = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 3) == 0) cyc[m] = ~cyc[m];
        stb[m] = 1'($urandom_range(0, 1));
      end
      rst = 1'($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
